// File: rtl/pbs_pkg.sv
// Shared types and constants for the PBS battle sequencing controller.
package pbs_pkg;

  localparam int unsigned HP_W   = 4;
  localparam int unsigned MOVE_W = 2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_MOVE = 4'd1,
    S_P_CALC    = 4'd2,
    S_P_APPLY   = 4'd3,
    S_P_SETTLE  = 4'd4,
    S_P_CHECK   = 4'd5,
    S_AI_THINK  = 4'd6,
    S_AI_CALC   = 4'd7,
    S_AI_APPLY  = 4'd8,
    S_AI_SETTLE = 4'd9,
    S_AI_CHECK  = 4'd10,
    S_DONE      = 4'd11
  } pbs_state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_AI     = 2'b10;
  localparam logic [1:0] WIN_DRAW   = 2'b11;

endpackage

// File: rtl/pbs_ctrl_if.sv
// Controller <-> datapath/player bundle for the PBS battle controller.
interface pbs_ctrl_if;
  import pbs_pkg::*;

  logic              start;
  logic              move_valid;
  logic [MOVE_W-1:0] move_sel;
  logic              move_ready;
  logic [HP_W-1:0]   p_hp;
  logic [HP_W-1:0]   AI_hp;
  logic              target;
  logic [MOVE_W-1:0] p_move;
  logic              actr;
  logic              calc_dmg;
  logic              app_dmg;
  logic [7:0]        turn_cnt;
  logic              game_over;
  logic [1:0]        winner;

  // Controller side
  modport master (
    input  start, move_valid, move_sel, p_hp, AI_hp,
    output move_ready, target, p_move, actr, calc_dmg, app_dmg,
           turn_cnt, game_over, winner
  );

  // Player / datapath side
  modport slave (
    output start, move_valid, move_sel, p_hp, AI_hp,
    input  move_ready, target, p_move, actr, calc_dmg, app_dmg,
           turn_cnt, game_over, winner
  );

endinterface

// File: rtl/pbs_wait_ctr.sv
// 4-bit wait down-counter shared by the HP settle and AI think states.
module pbs_wait_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  // Load on state entry, then count down and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pbs_ctrl.sv
// PBS battle sequencing controller: alternating player/AI turns, move
// handshake, AI think delay, HP settle wait and turn counting.
module pbs_ctrl
  import pbs_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned AI_DELAY   = 4,
  parameter int unsigned MAX_TURNS  = 16
) (
  input logic        clk,
  input logic        rst,
  pbs_ctrl_if.master bus
);

  // Counter is loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] AI_LD     = 4'(AI_DELAY - 1);
  localparam logic [7:0] MAX_T     = 8'(MAX_TURNS);

  pbs_state_t        state, state_nxt;
  logic [1:0]        winner_q, winner_nxt;
  logic [7:0]        turn_q;
  logic [MOVE_W-1:0] p_move_q;
  logic              move_ready_q, calc_q, app_q, actr_q, target_q, over_q;
  logic              cnt_load, cnt_zero, turn_inc, accept;
  logic [3:0]        cnt_val;

  pbs_wait_ctr u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign accept = bus.move_valid && move_ready_q;

  // Next-state, wait-counter load and outcome decode.
  always_comb begin
    state_nxt  = state;
    winner_nxt = winner_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    turn_inc   = 1'b0;
    unique case (state)
      S_IDLE:      if (bus.start) state_nxt = S_WAIT_MOVE;
      S_WAIT_MOVE: if (accept) state_nxt = S_P_CALC;
      S_P_CALC:    state_nxt = S_P_APPLY;
      S_P_APPLY: begin
        state_nxt = S_P_SETTLE;
        cnt_load  = 1'b1;
        cnt_val   = SETTLE_LD;
      end
      S_P_SETTLE:  if (cnt_zero) state_nxt = S_P_CHECK;
      S_P_CHECK: begin
        if (bus.AI_hp == '0) begin
          state_nxt  = S_DONE;
          winner_nxt = WIN_PLAYER;
        end else begin
          state_nxt = S_AI_THINK;
          cnt_load  = 1'b1;
          cnt_val   = AI_LD;
        end
      end
      S_AI_THINK:  if (cnt_zero) state_nxt = S_AI_CALC;
      S_AI_CALC:   state_nxt = S_AI_APPLY;
      S_AI_APPLY: begin
        state_nxt = S_AI_SETTLE;
        cnt_load  = 1'b1;
        cnt_val   = SETTLE_LD;
      end
      S_AI_SETTLE: if (cnt_zero) state_nxt = S_AI_CHECK;
      S_AI_CHECK: begin
        if (bus.p_hp == '0) begin
          state_nxt  = S_DONE;
          winner_nxt = WIN_AI;
        end else begin
          turn_inc = 1'b1;
          if (turn_q + 8'd1 == MAX_T) begin
            state_nxt  = S_DONE;
            winner_nxt = WIN_DRAW;
          end else begin
            state_nxt = S_WAIT_MOVE;
          end
        end
      end
      S_DONE:      state_nxt = S_DONE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State plus Moore outputs registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      winner_q     <= WIN_NONE;
      turn_q       <= '0;
      p_move_q     <= '0;
      move_ready_q <= 1'b0;
      calc_q       <= 1'b0;
      app_q        <= 1'b0;
      actr_q       <= 1'b0;
      target_q     <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      winner_q     <= winner_nxt;
      if (turn_inc) turn_q   <= turn_q + 8'd1;
      if (accept)   p_move_q <= bus.move_sel;
      move_ready_q <= (state_nxt == S_WAIT_MOVE);
      calc_q       <= (state_nxt == S_P_CALC)  || (state_nxt == S_AI_CALC);
      app_q        <= (state_nxt == S_P_APPLY) || (state_nxt == S_AI_APPLY);
      actr_q       <= state_nxt inside {S_AI_THINK, S_AI_CALC, S_AI_APPLY,
                                        S_AI_SETTLE, S_AI_CHECK};
      target_q     <= state_nxt inside {S_P_CALC, S_P_APPLY, S_P_SETTLE,
                                        S_P_CHECK};
      over_q       <= (state_nxt == S_DONE);
    end
  end

  assign bus.move_ready = move_ready_q;
  assign bus.calc_dmg   = calc_q;
  assign bus.app_dmg    = app_q;
  assign bus.actr       = actr_q;
  assign bus.target     = target_q;
  assign bus.p_move     = p_move_q;
  assign bus.turn_cnt   = turn_q;
  assign bus.game_over  = over_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pbs_ctrl.sv
// Self-checking bench for pbs_ctrl: whole games driven turn by turn with the
// bench acting as player and datapath.
module tb_pbs_ctrl;
  import pbs_pkg::*;

  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pbs_ctrl_if bus ();

  pbs_ctrl #(.SETTLE_CYC(S), .AI_DELAY(D), .MAX_TURNS(MAXT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         ai_ko;   // turn whose P_CHECK sees AI_hp == 0 (>= MAXT: never)
    int         p_ko;    // turn whose AI_CHECK sees p_hp == 0 (>= MAXT: never)
    logic [1:0] win;
    int         turns;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of a game from the rules alone: first zero-HP check wins,
  // else a draw after MAXT full turns.
  function automatic void ref_game(input int a, input int p,
                                   output logic [1:0] w, output int n);
    for (int t = 0; t < MAXT; t++) begin
      if (t == a) begin w = WIN_PLAYER; n = t; return; end
      if (t == p) begin w = WIN_AI;     n = t; return; end
    end
    w = WIN_DRAW;
    n = MAXT;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_sel   = '0;
    bus.p_hp       = 4'd9;
    bus.AI_hp      = 4'd9;
    #2;
    chk("rst_move_ready", bus.move_ready, 0);
    chk("rst_calc_dmg",   bus.calc_dmg,   0);
    chk("rst_app_dmg",    bus.app_dmg,    0);
    chk("rst_actr",       bus.actr,       0);
    chk("rst_target",     bus.target,     0);
    chk("rst_game_over",  bus.game_over,  0);
    chk("rst_p_move",     bus.p_move,     0);
    chk("rst_turn_cnt",   bus.turn_cnt,   0);
    chk("rst_winner",     bus.winner,     WIN_NONE);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic play_game(input int a, input int p,
                           input logic [1:0] exp_w, input int exp_n);
    logic [1:0] sel;
    int         endk, idle;
    bit         ph, cont;
    do_reset();
    chk("idle_no_ready", bus.move_ready, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ready_after_start", bus.move_ready, 1);
    for (int t = 0; t < MAXT; t++) begin
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        step();
        chk("ready_hold", bus.move_ready, 1);
      end
      sel            = 2'($urandom_range(0, 3));
      bus.move_sel   = sel;
      bus.move_valid = 1'b1;
      step();
      bus.move_valid = 1'b0;
      bus.AI_hp = (t == a) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.p_hp  = (t == p) ? 4'd0 : 4'($urandom_range(1, 15));
      endk = (t == a) ? 3 + S : 6 + 2 * S + D;
      for (int k = 0; k < endk; k++) begin
        ph = (k <= 2 + S);
        chk("calc_dmg",  bus.calc_dmg,  int'(k == 0 || k == 3 + S + D));
        chk("app_dmg",   bus.app_dmg,   int'(k == 1 || k == 4 + S + D));
        chk("busy_ready", bus.move_ready, 0);
        chk("busy_over", bus.game_over, 0);
        chk("turn_cnt_mid", bus.turn_cnt, t);
        chk("p_move", bus.p_move, sel);
        chk("actr", bus.actr, int'(!ph));
        chk("target", bus.target, int'(ph));
        // a different move offered while busy must be ignored
        bus.move_valid = (k >= 2);
        bus.move_sel   = ~sel;
        step();
      end
      bus.move_valid = 1'b0;
      cont = (t != a) && (t != p) && (t + 1 < MAXT);
      if (!cont) break;
      chk("ready_next_turn", bus.move_ready, 1);
      chk("turn_cnt_inc", bus.turn_cnt, t + 1);
    end
    chk("end_game_over", bus.game_over, 1);
    chk("end_winner", bus.winner, exp_w);
    chk("end_turn_cnt", bus.turn_cnt, exp_n);
    chk("end_ready", bus.move_ready, 0);
    for (int i = 0; i < 4; i++) begin
      bus.start      = 1'b1;
      bus.move_valid = 1'b1;
      step();
      chk("sticky_over", bus.game_over, 1);
      chk("sticky_winner", bus.winner, exp_w);
      chk("sticky_calc", bus.calc_dmg, 0);
      chk("sticky_ready", bus.move_ready, 0);
    end
    bus.start      = 1'b0;
    bus.move_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] w;
    int         n, a, p;

    tbl[0] = '{0, 9, WIN_PLAYER, 0};
    tbl[1] = '{9, 0, WIN_AI,     0};
    tbl[2] = '{9, 9, WIN_DRAW,   3};
    tbl[3] = '{2, 9, WIN_PLAYER, 2};
    tbl[4] = '{9, 1, WIN_AI,     1};
    tbl[5] = '{1, 1, WIN_PLAYER, 1};
    tbl[6] = '{2, 1, WIN_AI,     1};

    rst = 1'b1;
    bus.start = 1'b0; bus.move_valid = 1'b0; bus.move_sel = '0;
    bus.p_hp = 4'd9; bus.AI_hp = 4'd9;

    // Handshake and latency: move 2'b10, then next move_ready 6+2S+D later
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.move_sel   = 2'b10;
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    chk("hs_p_move", bus.p_move, 2);
    chk("hs_calc", bus.calc_dmg, 1);
    n = 0;
    while (!bus.move_ready && n < 40) begin
      step();
      n++;
    end
    chk("latency", n, 14);

    // Reset asserted during P_APPLY clears the pulse immediately
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.move_sel   = 2'b11;
    bus.move_valid = 1'b1;
    step();
    bus.move_valid = 1'b0;
    step();
    chk("pre_rst_app", bus.app_dmg, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_app", bus.app_dmg, 0);
    chk("mid_rst_target", bus.target, 0);
    chk("mid_rst_p_move", bus.p_move, 0);
    chk("mid_rst_ready", bus.move_ready, 0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("post_rst_idle", bus.move_ready, 0);
    chk("post_rst_calc", bus.calc_dmg, 0);

    for (int i = 0; i < 7; i++)
      play_game(tbl[i].ai_ko, tbl[i].p_ko, tbl[i].win, tbl[i].turns);

    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 4);
      p = $urandom_range(0, 4);
      ref_game(a, p, w, n);
      play_game(a, p, w, n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
